systolic_result_collector: RTL

- Downstream consumer of the systolic array driver. On start, it requests a flush and captures the array_width_p*array_height_p result words the driver streams out.
- Captured words are held in a local buffer, then re-emitted to the next stage over a valid/ready stream in row-major or column-major order, with a last marker and a done pulse.
- Hides the driver's flush/yumi protocol from the rest of the design.

---
 rtl/systolic_result_collector.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/systolic_result_collector.sv
// Collects one result matrix from the systolic array driver, then replays it over a valid/ready
// stream in row- or column-major order. Define RESULT_RELU_EN to clamp negative words at capture.
module systolic_result_collector #(
  parameter int unsigned width_p        = 32,
  parameter int unsigned array_width_p  = 2,
  parameter int unsigned array_height_p = 2,
  parameter int unsigned col_major_p    = 0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               start_i,
  output logic               flush_o,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               yumi_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [width_p-1:0] data_o,
  output logic               last_o,
  output logic               done_o,
  output logic               busy_o
);

  localparam int unsigned N    = array_width_p * array_height_p;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(N - 1);

  typedef enum logic [4:0] {
    StIdle    = 5'b00001,
    StFlush   = 5'b00010,
    StCapture = 5'b00100,
    StDrain   = 5'b01000,
    StDone    = 5'b10000
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cap_cnt_q, cap_cnt_d;
  logic [CntW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [width_p-1:0] mem_q [N];
  logic [width_p-1:0] mem_d [N];
  logic [width_p-1:0] wr_data;
  logic [CntW-1:0]   rd_addr;
  int unsigned       rd_idx;

  always_comb begin
`ifdef RESULT_RELU_EN
    wr_data = data_i[width_p-1] ? '0 : data_i;
`else
    wr_data = data_i;
`endif
  end

  // Column-major replay walks down each column of the row-major buffer.
  always_comb begin
    rd_idx = 32'(rd_cnt_q);
    if (col_major_p != 0) begin
      rd_addr = CntW'((rd_idx % array_height_p) * array_width_p + rd_idx / array_height_p);
    end else begin
      rd_addr = rd_cnt_q;
    end
  end

  always_comb begin
    flush_o = (state_q == StFlush);
    // Never consume a driver word while reset is being applied.
    yumi_o  = (state_q == StCapture) & valid_i & en_i & reset_i;
    valid_o = (state_q == StDrain);
    data_o  = valid_o ? mem_q[rd_addr] : '0;
    last_o  = valid_o & (rd_cnt_q == LastIdx);
    done_o  = (state_q == StDone);
    busy_o  = (state_q != StIdle);
  end

  always_comb begin
    mem_d = mem_q;
    if (yumi_o) begin
      mem_d[cap_cnt_q] = wr_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    cap_cnt_d = cap_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    if (en_i) begin
      unique case (state_q)
        StIdle: begin
          if (start_i) state_d = StFlush;
        end
        StFlush: begin
          state_d   = StCapture;
          cap_cnt_d = '0;
        end
        StCapture: begin
          if (yumi_o) begin
            if (cap_cnt_q == LastIdx) begin
              state_d   = StDrain;
              cap_cnt_d = '0;
              rd_cnt_d  = '0;
            end else begin
              cap_cnt_d = cap_cnt_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (ready_i) begin
            if (rd_cnt_q == LastIdx) begin
              state_d  = StDone;
              rd_cnt_d = '0;
            end else begin
              rd_cnt_d = rd_cnt_q + 1'b1;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= StIdle;
      cap_cnt_q <= '0;
      rd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      cap_cnt_q <= cap_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule
